// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Frame controller for a UART transmitter. A parallel word is accepted on a
// Data_Valid strobe and shifted out on TX_OUT as
//     start(0), WIDTH data bits LSB first, optional parity bit, stop(1).
// The parity bit itself is produced by a downstream parity stage that
// watches data_latched; this block only selects when to put it on the line.
//
// Ports
//   clk          : sole clock, rising edge active
//   rst          : asynchronous, active-high reset
//   P_DATA       : parallel word, sampled only on accept
//   Data_Valid   : request strobe, P_DATA valid while high
//   PAR_EN       : 1 = send a parity bit, sampled on accept
//   PAR_TYP      : parity type for the parity stage (not used here)
//   parity_bit   : parity of data_latched from the parity stage (registered)
//   data_latched : word captured on accept, feeds the parity stage
//   TX_OUT       : serial line, idle high
//   Busy         : high while a frame is in progress
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             parity_bit,
    output logic [WIDTH-1:0] data_latched,
    output logic             TX_OUT,
    output logic             Busy
);

    // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          tx_next;
    logic          busy_next;
    logic          accept;
    logic          par_en_latched;

    // PAR_TYP is consumed by the parity stage that sits beside this block;
    // it is tied off here so the port stays on the interface.
    logic          unused_par_typ;
    assign unused_par_typ = PAR_TYP;

    // Next-state logic. TX_OUT and Busy are registered, so the values
    // computed here are what the line shows during the *next* state.
    // Defaults describe the idle line, which is also where unused
    // encodings fall back to.
    always_comb begin
        state_next = IDLE;
        count_next = '0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        accept     = 1'b0;

        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    accept     = 1'b1;
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end

            START: begin
                state_next = DATA;
                count_next = '0;
                tx_next    = data_latched[0];
                busy_next  = 1'b1;
            end

            DATA: begin
                busy_next = 1'b1;
                if (count == LAST_BIT) begin
                    count_next = '0;
                    if (par_en_latched) begin
                        // data_latched has been stable since accept, so the
                        // registered parity_bit is already settled here.
                        state_next = PARITY;
                        tx_next    = parity_bit;
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end else begin
                    state_next = DATA;
                    count_next = count + CW'(1);
                    tx_next    = data_latched[count_next];
                end
            end

            PARITY: begin
                state_next = STOP;
                tx_next    = 1'b1;
                busy_next  = 1'b1;
            end

            STOP: begin
                // A pending request at the stop bit starts the next frame
                // immediately, so back-to-back frames have no idle gap.
                if (Data_Valid) begin
                    accept     = 1'b1;
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control registers. Reset drives the line high immediately so an
    // aborted frame never leaves a stuck start/data level on TX_OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            TX_OUT <= tx_next;
            Busy   <= busy_next;
        end
    end

    // Frame payload capture. Only loaded on accept, so P_DATA and PAR_EN
    // are free to change while a frame is on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_latched   <= '0;
            par_en_latched <= 1'b0;
        end else if (accept) begin
            data_latched   <= P_DATA;
            par_en_latched <= PAR_EN;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Self-checking bench for uart_tx_ctrl. Expected line levels come from a
// frame model (start, data LSB first, optional parity, stop) evaluated per
// bit index. A registered parity stage fed by data_latched and PAR_TYP
// drives the DUT parity_bit input.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] P_DATA;
    logic             Data_Valid;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             parity_bit;
    logic [WIDTH-1:0] data_latched;
    logic             TX_OUT;
    logic             Busy;

    int n_compared = 0;
    int n_failed   = 0;

    uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .parity_bit   (parity_bit),
        .data_latched (data_latched),
        .TX_OUT       (TX_OUT),
        .Busy         (Busy)
    );

    always #5 clk = ~clk;

    // Parity stage: even parity gives XOR of the data, odd inverts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_bit <= 1'b0;
        else     parity_bit <= (^data_latched) ^ PAR_TYP;
    end

    // Frame model: line level at bit index k of a frame.
    function automatic logic frame_bit(input logic [WIDTH-1:0] d, input logic pe,
                                       input logic pt, input int k);
        if (k == 0) return 1'b0;
        if (k <= WIDTH) return d[k-1];
        if (pe && k == WIDTH + 1) return (^d) ^ pt;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        Data_Valid = 1'b0;
        P_DATA = '0;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        #1;
        n_compared++;
        if (TX_OUT !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL reset_tx actual=%b required=1", TX_OUT);
        end
        n_compared++;
        if (Busy !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL reset_busy actual=%b required=0", Busy);
        end
        n_compared++;
        if (data_latched !== '0) begin
            n_failed++;
            $display("[TB] FAIL reset_data actual=%h required=00", data_latched);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_compared++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_failed++;
                $display("[TB] FAIL reset_idle i=%0d actual tx=%b busy=%b required tx=1 busy=0",
                         i, TX_OUT, Busy);
            end
        end
    endtask

    // Directed frames first, then random words, parity on/off and type.
    task automatic test_frames();
        logic [WIDTH-1:0] d;
        logic pe;
        logic pt;
        int len;
        for (int n = 0; n < 12; n++) begin
            case (n)
                0:       begin d = 8'hA5; pe = 1'b0; pt = 1'b0; end
                1:       begin d = 8'hA5; pe = 1'b1; pt = 1'b0; end
                2:       begin d = 8'h01; pe = 1'b1; pt = 1'b1; end
                3:       begin d = 8'h03; pe = 1'b1; pt = 1'b1; end
                default: begin d = WIDTH'($urandom); pe = 1'($urandom); pt = 1'($urandom); end
            endcase
            len = 2 + WIDTH + int'(pe);
            @(negedge clk);
            P_DATA = d;
            PAR_EN = pe;
            PAR_TYP = pt;
            Data_Valid = 1'b1;
            @(negedge clk);
            Data_Valid = 1'b0;
            P_DATA = WIDTH'($urandom);
            PAR_EN = 1'($urandom);
            n_compared++;
            if (data_latched !== d) begin
                n_failed++;
                $display("[TB] FAIL frames_latch n=%0d actual=%h required=%h", n, data_latched, d);
            end
            for (int k = 0; k < len; k++) begin
                n_compared++;
                if (TX_OUT !== frame_bit(d, pe, pt, k) || Busy !== 1'b1) begin
                    n_failed++;
                    $display("[TB] FAIL frames_bit n=%0d k=%0d actual tx=%b busy=%b required tx=%b busy=1",
                             n, k, TX_OUT, Busy, frame_bit(d, pe, pt, k));
                end
                @(negedge clk);
            end
            n_compared++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_failed++;
                $display("[TB] FAIL frames_idle n=%0d actual tx=%b busy=%b required tx=1 busy=0",
                         n, TX_OUT, Busy);
            end
        end
    endtask

    // Data_Valid held high: second word presented at the stop bit.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] d [2];
        logic pe [2];
        int len;
        d[0] = 8'h0F;
        d[1] = 8'hF0;
        pe[0] = 1'b0;
        pe[1] = 1'($urandom);
        PAR_TYP = 1'b0;
        @(negedge clk);
        P_DATA = d[0];
        PAR_EN = pe[0];
        Data_Valid = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            len = 2 + WIDTH + int'(pe[f]);
            n_compared++;
            if (data_latched !== d[f]) begin
                n_failed++;
                $display("[TB] FAIL b2b_latch f=%0d actual=%h required=%h", f, data_latched, d[f]);
            end
            if (f == 1) Data_Valid = 1'b0;
            for (int k = 0; k < len; k++) begin
                n_compared++;
                if (TX_OUT !== frame_bit(d[f], pe[f], 1'b0, k) || Busy !== 1'b1) begin
                    n_failed++;
                    $display("[TB] FAIL b2b_bit f=%0d k=%0d actual tx=%b busy=%b required tx=%b busy=1",
                             f, k, TX_OUT, Busy, frame_bit(d[f], pe[f], 1'b0, k));
                end
                if (f == 0 && k == len - 1) begin
                    P_DATA = d[1];
                    PAR_EN = pe[1];
                end
                @(negedge clk);
            end
        end
        n_compared++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL b2b_idle actual tx=%b busy=%b required tx=1 busy=0", TX_OUT, Busy);
        end
    endtask

    // New request pulsed mid-DATA must be ignored and never sent.
    task automatic test_ignore_during_frame();
        logic [WIDTH-1:0] d;
        logic pe;
        int len;
        d = WIDTH'($urandom);
        pe = 1'($urandom);
        PAR_TYP = 1'($urandom);
        len = 2 + WIDTH + int'(pe);
        @(negedge clk);
        P_DATA = d;
        PAR_EN = pe;
        Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        for (int k = 0; k < len; k++) begin
            n_compared++;
            if (TX_OUT !== frame_bit(d, pe, PAR_TYP, k) || Busy !== 1'b1) begin
                n_failed++;
                $display("[TB] FAIL ignore_bit k=%0d actual tx=%b busy=%b required tx=%b busy=1",
                         k, TX_OUT, Busy, frame_bit(d, pe, PAR_TYP, k));
            end
            Data_Valid = (k == 3);
            P_DATA = ~d;
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_failed++;
                $display("[TB] FAIL ignore_idle i=%0d actual tx=%b busy=%b required tx=1 busy=0",
                         i, TX_OUT, Busy);
            end
            @(negedge clk);
        end
    endtask

    // Reset during the 4th data bit, then a clean 0x3C frame.
    task automatic test_reset_mid_frame();
        logic [WIDTH-1:0] d;
        logic pe;
        int len;
        d = 8'h3C;
        pe = 1'b0;
        PAR_TYP = 1'b0;
        @(negedge clk);
        P_DATA = d;
        PAR_EN = pe;
        Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_compared++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0 || data_latched !== '0) begin
            n_failed++;
            $display("[TB] FAIL midrst_async actual tx=%b busy=%b data=%h required tx=1 busy=0 data=00",
                     TX_OUT, Busy, data_latched);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_compared++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_failed++;
                $display("[TB] FAIL midrst_idle i=%0d actual tx=%b busy=%b required tx=1 busy=0",
                         i, TX_OUT, Busy);
            end
        end
        pe = 1'($urandom);
        len = 2 + WIDTH + int'(pe);
        P_DATA = d;
        PAR_EN = pe;
        Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        for (int k = 0; k < len; k++) begin
            n_compared++;
            if (TX_OUT !== frame_bit(d, pe, 1'b0, k) || Busy !== 1'b1) begin
                n_failed++;
                $display("[TB] FAIL midrst_bit k=%0d actual tx=%b busy=%b required tx=%b busy=1",
                         k, TX_OUT, Busy, frame_bit(d, pe, 1'b0, k));
            end
            @(negedge clk);
        end
        n_compared++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL midrst_end actual tx=%b busy=%b required tx=1 busy=0", TX_OUT, Busy);
        end
    endtask

    initial begin
        $display("[TB] starting uart_tx_ctrl bench");
        test_reset();
        test_frames();
        test_back_to_back();
        test_ignore_during_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 P_DATA  input  WIDTH  parallel word to transmit; sampled only on accept.
REQ-005 Data_Valid  input  1  request strobe; P_DATA valid while high.
REQ-006 PAR_EN  input  1  1 = insert parity bit between data and stop; sampled on accept.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd; passed through unchanged to the parity stage, not used internally.
REQ-008 parity_bit  input  1  parity of data_latched from the downstream parity stage; its register adds one clk of latency.
REQ-009 data_latched  output  WIDTH  word captured on accept; drives the parity stage P_DATA.
REQ-010 TX_OUT  output  1  serial line, idle high.
REQ-011 Busy  output  1  high while a frame is in progress.

Function
REQ-012 States: IDLE, START, DATA, PARITY, STOP; state register, bit counter, TX_OUT and Busy are all registered.
REQ-013 Accept: in IDLE with Data_Valid=1 at a rising edge, the block latches P_DATA into data_latched and PAR_EN internally, and enters START on that edge.
REQ-014 In IDLE with Data_Valid=0, the block holds IDLE with TX_OUT=1 and Busy=0.
REQ-015 START: lasts exactly 1 clk with TX_OUT=0 and Busy=1, then the block enters DATA with the bit counter at 0.
REQ-016 DATA: lasts exactly WIDTH clks with TX_OUT=data_latched[counter], LSB first; the counter increments each clk.
REQ-017 At the DATA exit (counter = WIDTH-1), the block enters PARITY if the latched PAR_EN=1, otherwise STOP; the counter returns to 0.
REQ-018 PARITY: lasts exactly 1 clk with TX_OUT=parity_bit as sampled that cycle, then the block enters STOP.
REQ-019 STOP: lasts exactly 1 clk with TX_OUT=1 and Busy=1.
REQ-020 STOP exit, Data_Valid=1: the block performs an accept (REQ-013) and enters START directly, giving back-to-back frames with no idle gap.
REQ-021 STOP exit, Data_Valid=0: the block enters IDLE and drops Busy on the same edge.
REQ-022 Frame length is 2+WIDTH+PAR_EN clks, from the first START cycle to the last STOP cycle inclusive.
REQ-023 Data_Valid, P_DATA and PAR_EN are ignored in START, DATA and PARITY; data_latched is stable for the whole frame.
REQ-024 parity_bit is guaranteed settled at PARITY because data_latched is stable WIDTH+1 clks earlier; no handshake with the parity stage is required.
REQ-025 The bit counter is wide enough to hold WIDTH-1 and never wraps inside DATA.
REQ-026 Unused state encodings return to IDLE on the next clk with TX_OUT=1 and Busy=0.

Reset
REQ-027 rst=1 forces, immediately and without waiting for clk: state=IDLE, counter=0, data_latched=0, TX_OUT=1, Busy=0.
REQ-028 rst asserted mid-frame aborts the frame; TX_OUT goes to 1 asynchronously and no partial frame resumes.
REQ-029 After rst deasserts, the first accept occurs at the first rising edge that sees IDLE with Data_Valid=1.

Verification
REQ-030 The bench drives parity_bit from a reference parity_calc instance fed by data_latched and PAR_TYP.
REQ-031 WIDTH=8, PAR_EN=0, P_DATA=0xA5, 1-clk Data_Valid -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); Busy high for exactly 10 clks, then IDLE.
REQ-032 PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 -> 11-clk frame; parity cycle TX_OUT=0.
REQ-033 PAR_EN=1, PAR_TYP=1, P_DATA=0x01 -> parity cycle TX_OUT=0; PAR_EN=1, PAR_TYP=1, P_DATA=0x03 -> parity cycle TX_OUT=1.
REQ-034 Data_Valid held high with P_DATA=0x0F and then 0xF0 presented at STOP -> second START immediately follows the first STOP; Busy never drops between frames.
REQ-035 P_DATA changed and Data_Valid pulsed during DATA -> current frame bits unchanged; no extra frame sent.
REQ-036 rst asserted during the 4th DATA bit -> TX_OUT=1 and Busy=0 immediately; a new 0x3C request after release transmits a complete, correct frame.
